// File: rtl/intersection_ctrl.sv
// Two-way intersection scheduler: NS and EW signal heads plus a pedestrian walk phase,
// with an all-red clearance between any two conflicting grants.
module intersection_ctrl #(
    parameter int TW          = 8,
    parameter int RED_CLR_CYC = 4,
    parameter int YELLOW_CYC  = 10,
    parameter int GREEN_MIN   = 20,
    parameter int GREEN_MAX   = 50,
    parameter int WALK_CYC    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_ALL_RED   = 3'd1,
        S_NS_GREEN  = 3'd2,
        S_NS_YELLOW = 3'd3,
        S_EW_GREEN  = 3'd4,
        S_EW_YELLOW = 3'd5,
        S_PED_WALK  = 3'd6
    } state_t;

    localparam logic [1:0] L_OFF    = 2'd0;
    localparam logic [1:0] L_RED    = 2'd1;
    localparam logic [1:0] L_YELLOW = 2'd2;
    localparam logic [1:0] L_GREEN  = 2'd3;

    localparam logic [TW-1:0] RED_LAST    = TW'(RED_CLR_CYC - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] GMIN_LAST   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST   = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_CYC - 1);

    localparam int DWELL_LIMIT = (1 << TW) - 1;

    // Dwell parameters must fit the timer so no exit condition is ever skipped by a wrap.
    generate
        if (RED_CLR_CYC < 1 || RED_CLR_CYC > DWELL_LIMIT) begin : g_bad_red
            $error("RED_CLR_CYC out of range");
        end
        if (YELLOW_CYC < 1 || YELLOW_CYC > DWELL_LIMIT) begin : g_bad_yellow
            $error("YELLOW_CYC out of range");
        end
        if (GREEN_MIN < 1 || GREEN_MAX > DWELL_LIMIT || GREEN_MIN > GREEN_MAX) begin : g_bad_green
            $error("GREEN_MIN/GREEN_MAX out of range");
        end
        if (WALK_CYC < 1 || WALK_CYC > DWELL_LIMIT) begin : g_bad_walk
            $error("WALK_CYC out of range");
        end
    endgenerate

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic          ped_pend;
    logic          last_ns;     // 1 = last green was NS, 0 = EW
    logic          ns_to_yellow;
    logic          ew_to_yellow;
    logic          same_dir_only;

    // Green may end early only once the minimum is served and someone else is waiting.
    assign ns_to_yellow = ((timer >= GMIN_LAST) && (ew_req || ped_pend)) || (timer == GMAX_LAST);
    assign ew_to_yellow = ((timer >= GMIN_LAST) && (ns_req || ped_pend)) || (timer == GMAX_LAST);
    assign same_dir_only = last_ns ? (ns_req && !ew_req) : (ew_req && !ns_req);

    always_comb begin
        next_state = state;
        unique case (state)
            S_OFF:       next_state = S_ALL_RED;
            S_ALL_RED: begin
                if (timer == RED_LAST) begin
                    if (ped_pend)
                        next_state = S_PED_WALK;
                    else if (same_dir_only)
                        next_state = last_ns ? S_NS_GREEN : S_EW_GREEN;
                    else
                        next_state = last_ns ? S_EW_GREEN : S_NS_GREEN;
                end
            end
            S_NS_GREEN:  if (ns_to_yellow) next_state = S_NS_YELLOW;
            S_NS_YELLOW: if (timer == YELLOW_LAST) next_state = S_ALL_RED;
            S_EW_GREEN:  if (ew_to_yellow) next_state = S_EW_YELLOW;
            S_EW_YELLOW: if (timer == YELLOW_LAST) next_state = S_ALL_RED;
            S_PED_WALK:  if (timer == WALK_LAST) next_state = S_ALL_RED;
            default:     next_state = S_OFF;
        endcase
        if (!enable)
            next_state = S_OFF;
    end

    // Outputs are registered from next_state so they always match the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_OFF;
            timer    <= '0;
            ped_pend <= 1'b0;
            last_ns  <= 1'b0;
            ns_light <= L_OFF;
            ew_light <= L_OFF;
            walk     <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            state <= next_state;

            if (!enable || (next_state != state))
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (!enable)
                ped_pend <= 1'b0;
            else if ((next_state == S_PED_WALK) && (state != S_PED_WALK))
                ped_pend <= 1'b0;
            else if (ped_req && (state != S_OFF) && (state != S_PED_WALK))
                ped_pend <= 1'b1;

            if (next_state == S_NS_GREEN)
                last_ns <= 1'b1;
            else if (next_state == S_EW_GREEN)
                last_ns <= 1'b0;

            unique case (next_state)
                S_OFF: begin
                    ns_light <= L_OFF;
                    ew_light <= L_OFF;
                end
                S_NS_GREEN: begin
                    ns_light <= L_GREEN;
                    ew_light <= L_RED;
                end
                S_NS_YELLOW: begin
                    ns_light <= L_YELLOW;
                    ew_light <= L_RED;
                end
                S_EW_GREEN: begin
                    ns_light <= L_RED;
                    ew_light <= L_GREEN;
                end
                S_EW_YELLOW: begin
                    ns_light <= L_RED;
                    ew_light <= L_YELLOW;
                end
                default: begin
                    ns_light <= L_RED;
                    ew_light <= L_RED;
                end
            endcase

            walk    <= (next_state == S_PED_WALK);
            ped_ack <= (next_state == S_PED_WALK) && (state != S_PED_WALK);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed scenarios then random stimulus, every cycle
// compared against a phase/dwell model of the scheduling rules.
module tb_intersection_ctrl;

    localparam int RED_CLR = 4;
    localparam int YEL     = 10;
    localparam int GMIN    = 20;
    localparam int GMAX    = 50;
    localparam int WALKD   = 30;

    localparam int P_OFF = 0, P_AR = 1, P_NSG = 2, P_NSY = 3, P_EWG = 4, P_EWY = 5, P_WALK = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current phase, cycles spent in it, pending walk, last served direction.
    int m_phase;
    int m_age;
    bit m_ped;
    bit m_last_ns;
    int prev_obs;

    intersection_ctrl #(
        .TW(8), .RED_CLR_CYC(RED_CLR), .YELLOW_CYC(YEL),
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .WALK_CYC(WALKD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ns_req(ns_req), .ew_req(ew_req),
        .ped_req(ped_req), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
        .ped_ack(ped_ack), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ns_of(input int p);
        case (p)
            P_OFF:  return 0;
            P_NSG:  return 3;
            P_NSY:  return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int ew_of(input int p);
        case (p)
            P_OFF:  return 0;
            P_EWG:  return 3;
            P_EWY:  return 2;
            default: return 1;
        endcase
    endfunction

    // One clock edge of the scheduling rules, using the inputs present at the edge.
    task automatic model_step();
        int  nxt;
        bit  opp;
        if (!rst) begin
            m_phase = P_OFF; m_age = 0; m_ped = 0; m_last_ns = 0;
            return;
        end
        if (!enable) begin
            m_phase = P_OFF; m_age = 0; m_ped = 0;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            P_OFF: nxt = P_AR;
            P_AR: if (m_age + 1 == RED_CLR) begin
                if (m_ped) nxt = P_WALK;
                else if (m_last_ns && ns_req && !ew_req) nxt = P_NSG;
                else if (!m_last_ns && ew_req && !ns_req) nxt = P_EWG;
                else nxt = m_last_ns ? P_EWG : P_NSG;
            end
            P_NSG, P_EWG: begin
                opp = (m_phase == P_NSG) ? ew_req : ns_req;
                if ((m_age + 1 >= GMIN && (opp || m_ped)) || m_age + 1 == GMAX)
                    nxt = m_phase + 1;
            end
            P_NSY, P_EWY: if (m_age + 1 == YEL) nxt = P_AR;
            P_WALK: if (m_age + 1 == WALKD) nxt = P_AR;
            default: nxt = P_OFF;
        endcase
        if (ped_req && m_phase != P_OFF && m_phase != P_WALK) m_ped = 1;
        if (nxt == P_WALK && m_phase != P_WALK) m_ped = 0;
        if (nxt == P_NSG) m_last_ns = 1;
        if (nxt == P_EWG) m_last_ns = 0;
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    // Advance one clock and compare every output with the model at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("state", state_o, m_phase);
        check("ns_light", ns_light, ns_of(m_phase));
        check("ew_light", ew_light, ew_of(m_phase));
        check("walk", walk, m_phase == P_WALK);
        check("ped_ack", ped_ack, (m_phase == P_WALK) && (m_age == 0));
        check("conflict", (ns_light >= 2) && (ew_light >= 2), 0);
        if ((state_o == P_NSG || state_o == P_EWG) && prev_obs != int'(state_o))
            check("green_after_allred", prev_obs, P_AR);
        prev_obs = state_o;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Counts cycles the DUT stays in its current state, starting at its first cycle.
    task automatic measure(output int len);
        logic [2:0] s;
        s   = state_o;
        len = 0;
        while (state_o == s && len < 300) begin
            len++;
            cycle();
        end
    endtask

    task automatic expect_run(input string tag, input int exp_state, input int exp_len);
        int len;
        check({tag, "_state"}, state_o, exp_state);
        measure(len);
        check({tag, "_len"}, len, exp_len);
    endtask

    initial begin
        int len;
        rst = 0; enable = 1; ns_req = 0; ew_req = 0; ped_req = 1;
        m_phase = P_OFF; m_age = 0; m_ped = 0; m_last_ns = 0; prev_obs = 0;

        // Reset dominates enable and ped_req.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_state", state_o, 0);
            check("rst_lights", {ns_light, ew_light, walk, ped_ack}, 0);
        end
        rst = 1; ped_req = 0;
        cycle();

        // Free-running with no demand.
        expect_run("t2_ar", P_AR, RED_CLR);
        expect_run("t2_nsg", P_NSG, GMAX);
        expect_run("t2_nsy", P_NSY, YEL);
        expect_run("t2_ar2", P_AR, RED_CLR);
        expect_run("t2_ewg", P_EWG, GMAX);
        expect_run("t2_ewy", P_EWY, YEL);
        expect_run("t2_ar3", P_AR, RED_CLR);

        // EW demand shortens NS green to the minimum.
        ew_req = 1;
        expect_run("t3_nsg", P_NSG, GMIN);
        expect_run("t3_nsy", P_NSY, YEL);
        expect_run("t3_ar", P_AR, RED_CLR);
        ew_req = 0;
        expect_run("t3_ewg", P_EWG, GMAX);
        expect_run("t3_ewy", P_EWY, YEL);
        expect_run("t3_ar2", P_AR, RED_CLR);

        // Single-cycle pedestrian press during NS green.
        check("t4_nsg_state", state_o, P_NSG);
        cycles(5);
        ped_req = 1;
        cycle();
        ped_req = 0;
        measure(len);
        check("t4_nsg_len", len + 6, GMIN);
        expect_run("t4_nsy", P_NSY, YEL);
        expect_run("t4_ar", P_AR, RED_CLR);
        check("t4_walk_ack", {walk, ped_ack}, 2'b11);
        cycle();
        check("t4_ack_once", ped_ack, 0);
        measure(len);
        check("t4_walk_len", len + 1, WALKD);
        expect_run("t4_ar2", P_AR, RED_CLR);

        // NS-only demand: EW green cut short, then NS served twice in a row.
        ns_req = 1;
        expect_run("t5_ewg", P_EWG, GMIN);
        expect_run("t5_ewy", P_EWY, YEL);
        expect_run("t5_ar", P_AR, RED_CLR);
        expect_run("t5_nsg", P_NSG, GMAX);
        expect_run("t5_nsy", P_NSY, YEL);
        expect_run("t5_ar2", P_AR, RED_CLR);
        check("t5_ns_again", state_o, P_NSG);
        ns_req = 0;

        // Enable drop mid-green, then resume toward the other direction.
        cycles(12);
        enable = 0;
        cycle();
        check("t6_off", {state_o, ns_light, ew_light}, 0);
        enable = 1;
        cycle();
        expect_run("t6_ar", P_AR, RED_CLR);
        check("t6_ewg", state_o, P_EWG);

        // Reset in the middle of a walk phase drops the walk and any pending press.
        ped_req = 1;
        cycle();
        ped_req = 0;
        len = 0;
        while (state_o != P_WALK && len < 200) begin
            cycle();
            len++;
        end
        check("t6_reach_walk", state_o, P_WALK);
        cycles(3);
        ped_req = 1;
        rst = 0;
        cycle();
        check("t6_rst_walk", {state_o, walk}, 0);
        rst = 1; ped_req = 0;
        cycle();
        expect_run("t6_ar2", P_AR, RED_CLR);
        check("t6_no_pend", state_o, P_NSG);

        // Random traffic, presses, enable drops and occasional resets.
        for (int i = 0; i < 5000; i++) begin
            rst     = ($urandom_range(0, 399) != 0);
            enable  = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 29) == 0) ns_req = ~ns_req;
            if ($urandom_range(0, 29) == 0) ew_req = ~ew_req;
            ped_req = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
